// File: rtl/clk_gate_pkg.sv
// Shared types for the clock-gate idle/wake controller.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        CG_RUN,
        CG_DRAIN,
        CG_GATED,
        CG_WAKE
    } cgState_t;

endpackage

// File: rtl/clk_gate_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         resetN_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge resetN_i) begin
        if (!resetN_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-detect / wake controller driving the enable of one gated clock domain.
// Runs a 4-phase quiesce handshake before gating and a settle delay on wake.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned STAT_W      = 32
) (
    input  logic              clk_i,
    input  logic              resetN_i,
    input  logic              gateEn_i,
    input  logic              busy_i,
    input  logic              wakeReq_i,
    input  logic              quiesceAck_i,
    input  logic              clrStats_i,
    output logic              quiesceReq_o,
    output logic              clkEn_o,
    output logic              domainReady_o,
    output logic [STAT_W-1:0] gatedCycles_o,
    output logic [STAT_W-1:0] gateEvents_o
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    cgState_t         r_state;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] r_wake_cnt;
    logic             r_quiesce_req;
    logic             r_clk_en;
    logic             r_domain_ready;

    cgState_t         w_state_nxt;
    logic [CNT_W-1:0] w_idle_cnt_nxt;
    logic [CNT_W-1:0] w_wake_cnt_nxt;
    logic             w_quiesce_req_nxt;
    logic             w_clk_en_nxt;
    logic             w_domain_ready_nxt;

    logic             w_idle;
    logic             w_gate_event;
    logic             w_in_gated;

    assign w_idle       = gateEn_i & ~busy_i & ~wakeReq_i;
    assign w_gate_event = (r_state == CG_DRAIN) & w_idle & quiesceAck_i;
    assign w_in_gated   = (r_state == CG_GATED);

    // Next-state and next-output decode; abort (not idle) always wins over ack.
    always_comb begin
        w_state_nxt        = r_state;
        w_idle_cnt_nxt     = r_idle_cnt;
        w_wake_cnt_nxt     = r_wake_cnt;
        w_quiesce_req_nxt  = r_quiesce_req;
        w_clk_en_nxt       = r_clk_en;
        w_domain_ready_nxt = r_domain_ready;

        case (r_state)
            CG_RUN: begin
                if (!w_idle) begin
                    w_idle_cnt_nxt = '0;
                end else if (r_idle_cnt == IDLE_LAST) begin
                    w_state_nxt       = CG_DRAIN;
                    w_idle_cnt_nxt    = '0;
                    w_quiesce_req_nxt = 1'b1;
                end else begin
                    w_idle_cnt_nxt = r_idle_cnt + CNT_W'(1);
                end
            end
            CG_DRAIN: begin
                if (!w_idle) begin
                    w_state_nxt       = CG_RUN;
                    w_idle_cnt_nxt    = '0;
                    w_quiesce_req_nxt = 1'b0;
                end else if (quiesceAck_i) begin
                    w_state_nxt        = CG_GATED;
                    w_clk_en_nxt       = 1'b0;
                    w_domain_ready_nxt = 1'b0;
                end
            end
            CG_GATED: begin
                if (!w_idle) begin
                    w_state_nxt       = CG_WAKE;
                    w_wake_cnt_nxt    = '0;
                    w_clk_en_nxt      = 1'b1;
                    w_quiesce_req_nxt = 1'b0;
                end
            end
            CG_WAKE: begin
                // Settle window: inputs are ignored until the domain is declared ready.
                if (r_wake_cnt == WAKE_LAST) begin
                    w_state_nxt        = CG_RUN;
                    w_wake_cnt_nxt     = '0;
                    w_idle_cnt_nxt     = '0;
                    w_domain_ready_nxt = 1'b1;
                end else begin
                    w_wake_cnt_nxt = r_wake_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt        = CG_RUN;
                w_idle_cnt_nxt     = '0;
                w_wake_cnt_nxt     = '0;
                w_quiesce_req_nxt  = 1'b0;
                w_clk_en_nxt       = 1'b1;
                w_domain_ready_nxt = 1'b1;
            end
        endcase
    end

    // State, counters and outputs; reset leaves the clock running and the domain ready.
    always_ff @(posedge clk_i or negedge resetN_i) begin
        if (!resetN_i) begin
            r_state        <= CG_RUN;
            r_idle_cnt     <= '0;
            r_wake_cnt     <= '0;
            r_quiesce_req  <= 1'b0;
            r_clk_en       <= 1'b1;
            r_domain_ready <= 1'b1;
        end else begin
            r_state        <= w_state_nxt;
            r_idle_cnt     <= w_idle_cnt_nxt;
            r_wake_cnt     <= w_wake_cnt_nxt;
            r_quiesce_req  <= w_quiesce_req_nxt;
            r_clk_en       <= w_clk_en_nxt;
            r_domain_ready <= w_domain_ready_nxt;
        end
    end

    assign quiesceReq_o  = r_quiesce_req;
    assign clkEn_o       = r_clk_en;
    assign domainReady_o = r_domain_ready;

    sat_counter #(.W(STAT_W)) u_gated_cycles (
        .clk_i    (clk_i),
        .resetN_i (resetN_i),
        .clr_i    (clrStats_i),
        .inc_i    (w_in_gated),
        .cnt_o    (gatedCycles_o)
    );

    sat_counter #(.W(STAT_W)) u_gate_events (
        .clk_i    (clk_i),
        .resetN_i (resetN_i),
        .clr_i    (clrStats_i),
        .inc_i    (w_gate_event),
        .cnt_o    (gateEvents_o)
    );

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: vector table, async-reset sequence and randomized run vs a behavioural model.
module tb_clk_gate_ctrl;

    localparam int unsigned IDLE_N = 16;
    localparam int unsigned WAKE_N = 2;

    logic        clk_i = 1'b0;
    logic        resetN_i;
    logic        gateEn_i, busy_i, wakeReq_i, quiesceAck_i, clrStats_i;
    logic        req_w, en_w, rdy_w, req_n, en_n, rdy_n;
    logic [31:0] gc_w, ev_w;
    logic [3:0]  gc_n, ev_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    clk_gate_ctrl #(.IDLE_CYCLES(IDLE_N), .WAKE_CYCLES(WAKE_N), .CNT_W(8), .STAT_W(32)) dut (
        .clk_i(clk_i), .resetN_i(resetN_i), .gateEn_i(gateEn_i), .busy_i(busy_i),
        .wakeReq_i(wakeReq_i), .quiesceAck_i(quiesceAck_i), .clrStats_i(clrStats_i),
        .quiesceReq_o(req_w), .clkEn_o(en_w), .domainReady_o(rdy_w),
        .gatedCycles_o(gc_w), .gateEvents_o(ev_w)
    );

    clk_gate_ctrl #(.IDLE_CYCLES(IDLE_N), .WAKE_CYCLES(WAKE_N), .CNT_W(8), .STAT_W(4)) dut4 (
        .clk_i(clk_i), .resetN_i(resetN_i), .gateEn_i(gateEn_i), .busy_i(busy_i),
        .wakeReq_i(wakeReq_i), .quiesceAck_i(quiesceAck_i), .clrStats_i(clrStats_i),
        .quiesceReq_o(req_n), .clkEn_o(en_n), .domainReady_o(rdy_n),
        .gatedCycles_o(gc_n), .gateEvents_o(ev_n)
    );

    typedef struct {
        int unsigned n;
        logic gate, busy, wake, ack, clr;
        logic req, en, rdy;
        int unsigned ev, gc;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model: phase is read off the observable outputs; stats are counts since last clear.
    bit          m_req, m_en, m_rdy;
    int unsigned m_streak, m_wake_seen;
    longint unsigned raw_g, raw_e;

    function automatic longint unsigned sat(longint unsigned r, int w);
        longint unsigned mx;
        mx = (64'd1 << w) - 64'd1;
        return (r > mx) ? mx : r;
    endfunction

    task automatic model_reset();
        m_req = 1'b0; m_en = 1'b1; m_rdy = 1'b1;
        m_streak = 0; m_wake_seen = 0; raw_g = 0; raw_e = 0;
    endtask

    task automatic model_step();
        bit idle;
        bit inc_g, inc_e;
        idle  = gateEn_i & ~busy_i & ~wakeReq_i;
        inc_g = !m_en;
        inc_e = 1'b0;
        if (!m_en) begin
            if (!idle) begin m_en = 1'b1; m_req = 1'b0; m_wake_seen = 0; end
        end else if (m_req) begin
            if (!idle) begin
                m_req = 1'b0; m_streak = 0;
            end else if (quiesceAck_i) begin
                m_en = 1'b0; m_rdy = 1'b0; inc_e = 1'b1;
            end
        end else if (!m_rdy) begin
            m_wake_seen++;
            if (m_wake_seen == WAKE_N) begin m_rdy = 1'b1; m_streak = 0; end
        end else begin
            if (idle) begin
                m_streak++;
                if (m_streak == IDLE_N) begin m_req = 1'b1; m_streak = 0; end
            end else begin
                m_streak = 0;
            end
        end
        if (clrStats_i) begin raw_g = 0; raw_e = 0; end
        else begin raw_g += 64'(inc_g); raw_e += 64'(inc_e); end
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic g, logic b, logic w, logic a, logic c);
        gateEn_i = g; busy_i = b; wakeReq_i = w; quiesceAck_i = a; clrStats_i = c;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic check_model(string tag);
        chk($sformatf("%s.req", tag),  64'(req_w), 64'(m_req));
        chk($sformatf("%s.en", tag),   64'(en_w),  64'(m_en));
        chk($sformatf("%s.rdy", tag),  64'(rdy_w), 64'(m_rdy));
        chk($sformatf("%s.gc", tag),   64'(gc_w),  sat(raw_g, 32));
        chk($sformatf("%s.ev", tag),   64'(ev_w),  sat(raw_e, 32));
        chk($sformatf("%s.gc4", tag),  64'(gc_n),  sat(raw_g, 4));
        chk($sformatf("%s.ev4", tag),  64'(ev_n),  sat(raw_e, 4));
        chk($sformatf("%s.en4", tag),  64'(en_n),  64'(m_en));
    endtask

    initial begin
        resetN_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #12;
        chk("reset.req", 64'(req_w), 64'd0);
        chk("reset.en",  64'(en_w),  64'd1);
        chk("reset.rdy", 64'(rdy_w), 64'd1);
        chk("reset.gc",  64'(gc_w),  64'd0);
        chk("reset.ev",  64'(ev_w),  64'd0);
        @(negedge clk_i);
        resetN_i = 1'b1;

        //           n  gate  busy  wake  ack   clr   req   en    rdy  ev  gc
        tbl.push_back('{15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0});
        tbl.push_back('{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0});
        tbl.push_back('{1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0});
        tbl.push_back('{49, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 49});
        tbl.push_back('{1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 50});
        tbl.push_back('{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 50});
        tbl.push_back('{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 50});
        tbl.push_back('{16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 50});
        tbl.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 50});
        tbl.push_back('{10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 50});
        tbl.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 50});
        tbl.push_back('{15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 50});
        tbl.push_back('{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 50});
        tbl.push_back('{1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 50});
        tbl.push_back('{20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 70});
        tbl.push_back('{1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0});
        tbl.push_back('{1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1});
        tbl.push_back('{1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 2});
        tbl.push_back('{2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 2});
        tbl.push_back('{5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 2});

        foreach (tbl[i]) begin
            drive(tbl[i].gate, tbl[i].busy, tbl[i].wake, tbl[i].ack, tbl[i].clr);
            repeat (tbl[i].n) tick();
            chk($sformatf("vec%0d.req", i), 64'(req_w), 64'(tbl[i].req));
            chk($sformatf("vec%0d.en", i),  64'(en_w),  64'(tbl[i].en));
            chk($sformatf("vec%0d.rdy", i), 64'(rdy_w), 64'(tbl[i].rdy));
            chk($sformatf("vec%0d.ev", i),  64'(ev_w),  64'(tbl[i].ev));
            chk($sformatf("vec%0d.gc", i),  64'(gc_w),  64'(tbl[i].gc));
            chk($sformatf("vec%0d.ev4", i), 64'(ev_n),  sat(64'(tbl[i].ev), 4));
            chk($sformatf("vec%0d.gc4", i), 64'(gc_n),  sat(64'(tbl[i].gc), 4));
        end

        // Asynchronous reset while gated: outputs recover between clock edges.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (IDLE_N) tick();
        quiesceAck_i = 1'b1;
        repeat (4) tick();
        chk("gated.en", 64'(en_w), 64'd0);
        #2;
        resetN_i = 1'b0;
        #1;
        chk("areset.en",  64'(en_w),  64'd1);
        chk("areset.rdy", 64'(rdy_w), 64'd1);
        chk("areset.req", 64'(req_w), 64'd0);
        chk("areset.gc",  64'(gc_w),  64'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        resetN_i = 1'b1;
        model_reset();

        // Randomized run with a loosely 4-phase domain.
        for (int c = 0; c < 3000; c++) begin
            gateEn_i     = ($urandom_range(0, 99) < 97);
            busy_i       = ($urandom_range(0, 99) < 3);
            wakeReq_i    = ($urandom_range(0, 99) < 2);
            clrStats_i   = ($urandom_range(0, 99) < 1);
            quiesceAck_i = m_req ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 10);
            tick();
            check_model($sformatf("rnd%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
